// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the fetch PC and picks the next one from
// increment, branch, jump, call or return. Define PC_RAS_EN to build the return-address stack.
module pc_sequencer #(
   parameter int             n            = 32,
   parameter int             INC          = 4,
   parameter logic [n-1:0]   RESET_VECTOR = '0,
   parameter int             RAS_DEPTH    = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         stall,
   input  logic         branch_taken,
   input  logic [n-1:0] branch_target,
   input  logic         jump,
   input  logic [n-1:0] jump_target,
   input  logic         call,
   input  logic         ret,
   output logic [n-1:0] pc,
   output logic [n-1:0] pc_plus,
   output logic         ras_empty,
   output logic         ras_full,
   output logic         ras_err
);

   localparam logic [n-1:0] ALIGN_MASK = ~(n'(INC - 1));

   function automatic logic [n-1:0] align(input logic [n-1:0] a);
      return a & ALIGN_MASK;
   endfunction

   logic [n-1:0] r_pc;
   logic [n-1:0] w_pc_plus;
   logic [n-1:0] w_pc_nxt;

   assign w_pc_plus = r_pc + n'(INC);
   assign pc        = r_pc;
   assign pc_plus   = w_pc_plus;

`ifdef PC_RAS_EN
   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   logic [n-1:0]  r_ras [RAS_DEPTH];
   logic [PW-1:0] r_wp;
   logic [CW-1:0] r_cnt;
   logic          r_err;
   logic          w_push;
   logic          w_pop;
   logic          w_err_set;
   logic          w_full;
   logic          w_empty;
   logic [PW-1:0] w_top;

   assign w_full    = (r_cnt == CW'(RAS_DEPTH));
   assign w_empty   = (r_cnt == '0);
   assign w_top     = r_wp - 1'b1;
   assign ras_empty = w_empty;
   assign ras_full  = w_full;
   assign ras_err   = r_err;

   always_comb begin
      w_pc_nxt  = w_pc_plus;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_err_set = 1'b0;
      if (stall) begin
         w_pc_nxt = r_pc;
      end else if (ret) begin
         // A simultaneous call is dropped and flagged; an empty pop falls through to pc_plus.
         w_err_set = call | w_empty;
         if (!w_empty) begin
            w_pop    = 1'b1;
            w_pc_nxt = align(r_ras[w_top]);
         end
      end else if (call || jump) begin
         w_pc_nxt  = align(jump_target);
         w_push    = call;
         w_err_set = call & w_full;
      end else if (branch_taken) begin
         w_pc_nxt = align(branch_target);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc  <= RESET_VECTOR;
         r_wp  <= '0;
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         r_pc <= w_pc_nxt;
         if (w_err_set) r_err <= 1'b1;
         // Circular write pointer: when full, the push lands on the oldest entry.
         if (w_push) begin
            r_wp <= r_wp + 1'b1;
            if (!w_full) r_cnt <= r_cnt + 1'b1;
         end else if (w_pop) begin
            r_wp  <= w_top;
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   // Stack contents carry no reset; the count alone decides validity.
   always_ff @(posedge clk) begin
      if (w_push) r_ras[r_wp] <= w_pc_plus;
   end
`else
   logic w_unused;

   assign w_unused  = ret;
   assign ras_empty = 1'b1;
   assign ras_full  = 1'b0;
   assign ras_err   = 1'b0;

   always_comb begin
      w_pc_nxt = w_pc_plus;
      if (stall) begin
         w_pc_nxt = r_pc;
      end else if (call || jump) begin
         w_pc_nxt = align(jump_target);
      end else if (branch_taken) begin
         w_pc_nxt = align(branch_target);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc <= RESET_VECTOR;
      end else begin
         r_pc <= w_pc_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (n=32, INC=4, RAS_DEPTH=4, RESET_VECTOR=0x100);
// the RAS scenarios are selected when PC_RAS_EN is defined.
module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        call;
   logic        ret;
   logic [31:0] pc;
   logic [31:0] pc_plus;
   logic        ras_empty;
   logic        ras_full;
   logic        ras_err;

   int total = 0;
   int bad   = 0;

   pc_sequencer #(
      .n            (32),
      .INC          (4),
      .RESET_VECTOR (32'h100),
      .RAS_DEPTH    (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .call          (call),
      .ret           (ret),
      .pc            (pc),
      .pc_plus       (pc_plus),
      .ras_empty     (ras_empty),
      .ras_full      (ras_full),
      .ras_err       (ras_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic clear_ctl();
      stall = 0; branch_taken = 0; branch_target = '0;
      jump = 0; jump_target = '0; call = 0; ret = 0;
   endtask

   // Apply controls for one clock edge; return on the following falling edge.
   task automatic cyc(input logic s, input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt,
                      input logic c, input logic r);
      stall = s; branch_taken = b; branch_target = bt;
      jump = j; jump_target = jt; call = c; ret = r;
      @(posedge clk);
      @(negedge clk);
      clear_ctl();
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      clear_ctl();
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_pc", pc, 32'h100);
      chk("rst_pc_plus", pc_plus, 32'h104);
      chk("rst_empty", 32'(ras_empty), 32'd1);
      chk("rst_full", 32'(ras_full), 32'd0);
      chk("rst_err", 32'(ras_err), 32'd0);

      rst = 1'b1;
      chk("rel_pc", pc, 32'h100);
      idle(); chk("inc1", pc, 32'h104);
      idle(); chk("inc2", pc, 32'h108);
      idle(); chk("inc3", pc, 32'h10C);
      rst = 1'b0;
      #1;
      chk("async_rst", pc, 32'h100);
      #1;
      rst = 1'b1;

      cyc(0, 0, 0, 1, 32'h207, 0, 0);  chk("jmp_align", pc, 32'h204);
      cyc(0, 1, 32'h203, 0, 0, 0, 0);  chk("br_align", pc, 32'h200);
      cyc(0, 1, 32'h700, 1, 32'h300, 0, 0); chk("jmp_over_br", pc, 32'h300);
      cyc(1, 1, 32'h700, 1, 32'h800, 0, 0); chk("stall_hold", pc, 32'h300);
      cyc(0, 0, 0, 1, 32'hFFFFFFFC, 0, 0);
      chk("wrap_pc", pc, 32'hFFFFFFFC);
      chk("wrap_plus", pc_plus, 32'h0);
      idle();
      chk("wrap_next", pc, 32'h0);
      chk("wrap_err", 32'(ras_err), 32'd0);

`ifdef PC_RAS_EN
      // Nesting
      do_reset();
      cyc(0, 0, 0, 0, 32'h500, 1, 0); chk("call1", pc, 32'h500);
      chk("call1_empty", 32'(ras_empty), 32'd0);
      cyc(0, 0, 0, 0, 32'h600, 1, 0); chk("call2", pc, 32'h600);
      cyc(0, 0, 0, 0, 0, 0, 1);       chk("ret1", pc, 32'h504);
      cyc(0, 0, 0, 0, 0, 0, 1);       chk("ret2", pc, 32'h104);
      chk("nest_empty", 32'(ras_empty), 32'd1);
      chk("nest_err", 32'(ras_err), 32'd0);

      // Priority, with stall first
      cyc(0, 0, 0, 1, 32'h3FC, 0, 0);
      cyc(0, 0, 0, 0, 32'h800, 1, 0); chk("prio_call", pc, 32'h800);
      cyc(1, 1, 32'h200, 1, 32'h300, 0, 1);
      chk("prio_stall_pc", pc, 32'h800);
      chk("prio_stall_empty", 32'(ras_empty), 32'd0);
      cyc(0, 1, 32'h200, 1, 32'h300, 0, 1);
      chk("prio_ret", pc, 32'h400);
      chk("prio_empty", 32'(ras_empty), 32'd1);
      chk("prio_err", 32'(ras_err), 32'd0);

      // Overflow then drain
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         cyc(0, 0, 0, 0, 32'(i) << 12, 1, 0);
         chk("ovf_call", pc, 32'(i) << 12);
         if (i == 4) begin
            chk("full4", 32'(ras_full), 32'd1);
            chk("err4", 32'(ras_err), 32'd0);
         end
      end
      chk("ovf_full", 32'(ras_full), 32'd1);
      chk("ovf_err", 32'(ras_err), 32'd1);
      for (int i = 4; i >= 1; i--) begin
         cyc(0, 0, 0, 0, 0, 0, 1);
         chk("ovf_ret", pc, (32'(i) << 12) + 32'd4);
      end
      chk("drain_empty", 32'(ras_empty), 32'd1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("ret_past_empty", pc, 32'h1008);

      // Underflow from fresh reset
      do_reset();
      chk("fresh_err", 32'(ras_err), 32'd0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("udf_pc", pc, 32'h104);
      chk("udf_err", 32'(ras_err), 32'd1);

      // call and ret together: ret wins, no push
      do_reset();
      cyc(0, 0, 0, 0, 32'h500, 1, 0);
      cyc(0, 0, 0, 0, 32'h900, 1, 1);
      chk("cr_pc", pc, 32'h104);
      chk("cr_err", 32'(ras_err), 32'd1);
      chk("cr_empty", 32'(ras_empty), 32'd1);
`else
      do_reset();
      cyc(0, 0, 0, 0, 32'h500, 1, 0); chk("nr_call", pc, 32'h500);
      chk("nr_empty", 32'(ras_empty), 32'd1);
      cyc(0, 0, 0, 0, 0, 0, 1);       chk("nr_ret", pc, 32'h504);
      cyc(0, 1, 32'h700, 0, 0, 0, 1); chk("nr_ret_br", pc, 32'h700);
      chk("nr_empty2", 32'(ras_empty), 32'd1);
      chk("nr_full", 32'(ras_full), 32'd0);
      chk("nr_err", 32'(ras_err), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
